// File: rtl/ddio_capture.sv
// ddio_capture: double-data-rate input capture.
// Each lane is sampled on both edges of inclock. The falling-edge sample is
// moved into the rising-edge domain so that the two outputs form a pair that
// changes only on rising edges. dataout_l carries the older bit of the pair
// (the falling edge just before rising edge k) and dataout_h the newer bit
// (rising edge k).
// aclr_n is an asynchronous clear. The integrating logic releases it
// synchronously to the falling edge, so this block has no reset synchronizer.
module ddio_capture #(
    parameter int WIDTH = 8
) (
    input  logic             inclock,
    input  logic             aclr_n,
    input  logic             inclocken,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] dataout_h,
    output logic [WIDTH-1:0] dataout_l
);

    logic [WIDTH-1:0] r_rise_q;     // rising-edge sample
    logic [WIDTH-1:0] r_fall_q;     // falling-edge sample
    logic [WIDTH-1:0] r_fall_sync;  // falling-edge sample moved to the rising edge

    // Capture the falling-edge bit of each lane.
    // NOTE: every bank clears asynchronously. A reset in the middle of a pair
    // therefore discards the half that has already been captured.
    always_ff @(negedge inclock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_fall_q <= '0;
        end else if (inclocken) begin
            r_fall_q <= datain;
        end
    end

    // Capture the rising-edge bit and move the held falling-edge bit forward.
    // NOTE: non-blocking assignments make r_fall_sync take the value that
    // r_fall_q held before this edge.
    always_ff @(posedge inclock or negedge aclr_n) begin
        if (!aclr_n) begin
            r_rise_q    <= '0;
            r_fall_sync <= '0;
        end else if (inclocken) begin
            r_rise_q    <= datain;
            r_fall_sync <= r_fall_q;
        end
    end

    assign dataout_h = r_rise_q;
    assign dataout_l = r_fall_sync;

endmodule

// File: tb/tb_ddio_capture.sv
// tb_ddio_capture: scoreboard bench for ddio_capture.
// Two instances are tested together:
//   - dut8 uses WIDTH=8.
//   - dut1 uses WIDTH=1 and is driven from lane 0.
// The stimulus side models the expected output pair after every clock edge and
// pushes it into a queue. The monitor pops one entry 1 ns after each edge and
// compares it with both DUTs.
module tb_ddio_capture;

    logic       inclock;
    logic       aclr_n;
    logic       inclocken;
    logic [7:0] datain;
    logic [7:0] dataout_h;
    logic [7:0] dataout_l;
    logic [0:0] datain1;
    logic [0:0] dataout_h1;
    logic [0:0] dataout_l1;

    assign datain1 = datain[0:0];

    ddio_capture #(.WIDTH(8)) dut8 (
        .inclock   (inclock),
        .aclr_n    (aclr_n),
        .inclocken (inclocken),
        .datain    (datain),
        .dataout_h (dataout_h),
        .dataout_l (dataout_l)
    );

    ddio_capture #(.WIDTH(1)) dut1 (
        .inclock   (inclock),
        .aclr_n    (aclr_n),
        .inclocken (inclocken),
        .datain    (datain1),
        .dataout_h (dataout_h1),
        .dataout_l (dataout_l1)
    );

    // Rising edges fall at 5, 15, 25, ... and falling edges at 10, 20, ...
    initial begin
        inclock = 1'b0;
        forever #5 inclock = ~inclock;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: the last accepted falling-edge bit and the pair that
    // is currently on the outputs.
    logic [7:0]  m_fall;
    logic [7:0]  m_h;
    logic [7:0]  m_l;
    logic [15:0] exp_q[$];  // {h, l} expected after each edge

    // One full clock. The falling-edge data f is driven after the rising edge,
    // and the rising-edge data r is driven after the falling edge.
    // arst asserts reset mid-cycle, just after the rising edge.
    // rel releases reset just after the falling edge.
    task automatic do_cycle(input logic [7:0] f, input logic en_f,
                            input logic [7:0] r, input logic en_r,
                            input logic arst = 1'b0, input logic rel = 1'b0);
        @(posedge inclock);
        #2;
        if (arst) begin
            aclr_n = 1'b0;
            m_fall = '0;
            m_h    = '0;
            m_l    = '0;
            #1;
            check("arst_h", {56'd0, dataout_h}, 64'd0);
            check("arst_l", {56'd0, dataout_l}, 64'd0);
        end
        datain    = f;
        inclocken = en_f;
        if (aclr_n && en_f) m_fall = f;
        exp_q.push_back({m_h, m_l});      // outputs hold across the falling edge

        @(negedge inclock);
        #2;
        if (rel) aclr_n = 1'b1;
        datain    = r;
        inclocken = en_r;
        if (aclr_n && en_r) begin
            m_h = r;
            m_l = m_fall;
        end
        exp_q.push_back({m_h, m_l});
    endtask

    // Monitor: after every edge, compare both DUTs with the next expected pair.
    initial begin
        logic [15:0] e;
        forever begin
            @(posedge inclock or negedge inclock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("h8", {56'd0, dataout_h},  {56'd0, e[15:8]});
                check("l8", {56'd0, dataout_l},  {56'd0, e[7:0]});
                check("h1", {63'd0, dataout_h1}, {63'd0, e[8]});
                check("l1", {63'd0, dataout_l1}, {63'd0, e[0]});
            end
        end
    end

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        aclr_n    = 1'b0;
        inclocken = 1'b1;
        datain    = 8'hFF;
        m_fall    = '0;
        m_h       = '0;
        m_l       = '0;

        // Reset held with datain toggling; then release after a falling edge.
        repeat (4) do_cycle(8'hFF, 1'b1, 8'h00, 1'b1);
        do_cycle(8'hFF, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);   // first rise: h=5A, l=0

        // Pair order.
        do_cycle(8'hA5, 1'b1, 8'h3C, 1'b1);
        do_cycle(8'h3C, 1'b1, 8'hA5, 1'b1);

        // Stream of alternating values.
        repeat (6) do_cycle(8'hFF, 1'b1, 8'h00, 1'b1);

        // Enable low for 3 cycles while the data changes, then resume.
        repeat (3) do_cycle(8'($urandom), 1'b0, 8'($urandom), 1'b0);
        do_cycle(8'h12, 1'b1, 8'h34, 1'b1);

        // Lane independence.
        repeat (3) do_cycle(8'h80, 1'b1, 8'h01, 1'b1);

        // Enable low at the falling edge only: fall_sync re-takes the held value.
        do_cycle(8'hC3, 1'b1, 8'h11, 1'b1);
        do_cycle(8'h77, 1'b0, 8'h22, 1'b1);

        // Reset mid-operation discards the partial pair.
        do_cycle(8'hE7, 1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
        do_cycle(8'hFF, 1'b1, 8'h00, 1'b1);
        do_cycle(8'hFF, 1'b1, 8'h6E, 1'b1, 1'b0, 1'b1);

        // Randomized traffic with random per-edge enables.
        for (int i = 0; i < 60; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            do_cycle(a, 1'($urandom_range(0, 3) != 0), b, 1'($urandom_range(0, 3) != 0));
        end

        // Let the monitor drain the queue (bounded wait).
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge inclock);
        #2;
        check("drain", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
